// File: rtl/ir_trace_ctrl.sv
// ir_trace_ctrl: debug trace sequencer for the 14-bit IR stream.
// The block arms on Trace_en and waits for a trigger opcode. It then captures
// IR words, each with an 8-bit cycle-delta stamp, into a FIFO that is read out
// through a first-word-fall-through valid/ready port.
// Build option: define IR_TRACE_WRAP_EN so that a full FIFO overwrites its
// oldest entry (circular buffer). By default a full FIFO drops the new word.
// Debug only; not part of FPGA synthesis builds.

module ir_trace_ctrl #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter logic [5:0]  TRIG_OPCODE = 6'b011011,
    parameter int unsigned CAPTURE_LEN = 32
) (
    input  logic                  Clock_pin,
    input  logic                  Reset_pin,
    input  logic [13:0]           IR,
    input  logic                  IR_load,
    input  logic                  Trace_en,
    input  logic                  Rd_ready,
    output logic                  Rd_valid,
    output logic [21:0]           Rd_data,
    output logic [DEPTH_LOG2:0]   Count,
    output logic [1:0]            State,
    output logic                  Overflow
);

    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CAP_W = $clog2(CAPTURE_LEN + 1);
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAPTURE_LEN);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [13:0]      STALL_WORD = 14'h3FFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic [CAP_W-1:0]    cap;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic [21:0]         mem [DEPTH];

    logic                trig_hit;
    logic                run_eff;
    logic                capture;
    logic                arm;
    logic                full;
    logic                pop;
    logic                write;
    logic                rd_adv;
    logic                lost;
    logic [CAP_W-1:0]    cap_next;

    // Capture qualification and FIFO push/pop decisions for this edge
    always_comb begin
        trig_hit = IR_load && (IR[13:8] == TRIG_OPCODE);
        // The trigger edge itself already behaves as RUN
        run_eff  = Trace_en && ((state == S_RUN) || ((state == S_ARMED) && trig_hit));
        capture  = run_eff && IR_load && (IR != STALL_WORD);
        arm      = Trace_en && (state == S_IDLE);
        full     = (count == CNT_FULL);
        pop      = (count != '0) && Rd_ready;
        cap_next = cap + CAP_W'(1);
        lost     = capture && full && !pop;
`ifdef IR_TRACE_WRAP_EN
        // Circular buffer: always write, evict the oldest entry when full
        write    = capture;
        rd_adv   = pop || lost;
`else
        // Stop-on-full: the new word is dropped and the contents are untouched
        write    = capture && !lost;
        rd_adv   = pop;
`endif
    end

    // Trace FSM, delta stamp, capture counter and FIFO bookkeeping
    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cap      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (!Trace_en) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE:  state <= S_ARMED;
                    S_ARMED: if (trig_hit) state <= (cap_next == CAP_LAST) ? S_DONE : S_RUN;
                    S_RUN:   if (capture && (cap_next == CAP_LAST)) state <= S_DONE;
                    default: state <= state;
                endcase
            end

            if (arm || capture) begin
                cnt <= '0;
            end else if (cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end

            if (arm) begin
                cap <= '0;
            end else if (capture) begin
                cap <= cap_next;
            end

            if (arm) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (write) wr_ptr <= wr_ptr + PTR_W'(1);
                if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
                if (write && !rd_adv) begin
                    count <= count + CNT_W'(1);
                end else if (!write && rd_adv) begin
                    count <= count - CNT_W'(1);
                end
                if (lost) overflow <= 1'b1;
            end
        end
    end

    // Entry storage: stamp is the delta count before this edge clears it
    always_ff @(posedge Clock_pin) begin
        if (write) begin
            mem[wr_ptr] <= {cnt, IR};
        end
    end

    // Fall-through read port and status outputs
    assign Rd_valid = (count != '0);
    assign Rd_data  = Rd_valid ? mem[rd_ptr] : 22'd0;
    assign Count    = count;
    assign State    = state;
    assign Overflow = overflow;

endmodule
